// File: rtl/serial_mod_pkg.sv
// Shared types and helpers for the serial modulo-N checker.
// Optional feature macro used by the top: SERIAL_MOD_LSB_FIRST_EN.
package serial_mod_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // $clog2 with a floor of 1 so single-value ranges still get a real bit
   function automatic int clog2_min1(input int v);
      int r;
      r = $clog2(v);
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/mod_n_step.sv
// Single-step modular reduction: a < 2*DIVISOR, so one conditional
// subtract of DIVISOR yields a mod DIVISOR.
module mod_n_step
   import serial_mod_pkg::*;
#(
   parameter int DIVISOR = 3,
   localparam int RW = clog2_min1(DIVISOR)
) (
   input  logic [RW:0]   a,
   output logic [RW-1:0] y
);

   localparam logic [RW:0] NV = (RW+1)'(DIVISOR);

   // Reduce by at most one modulus
   always_comb begin
      y = a[RW-1:0];
      if (a >= NV) y = RW'(a - NV);
   end

endmodule

// File: rtl/serial_mod_n_checker.sv
// Streaming divisibility checker: tracks the running value of a framed
// serial bitstream modulo DIVISOR. MSB-first by default; defining
// SERIAL_MOD_LSB_FIRST_EN adds a per-frame lsb_first mode.
module serial_mod_n_checker
   import serial_mod_pkg::*;
#(
   parameter int DIVISOR = 3,
   parameter int MAX_LEN = 32,
   localparam int RW = clog2_min1(DIVISOR),
   localparam int LW = clog2_min1(MAX_LEN + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   input  logic          in_bit,
   input  logic          in_last,
`ifdef SERIAL_MOD_LSB_FIRST_EN
   input  logic          lsb_first,
`endif
   output logic          out_div,
   output logic [RW-1:0] out_rem,
   output logic [LW-1:0] out_len,
   output logic          out_done,
   output logic          busy,
   output logic          err_ovf
);

   if (DIVISOR < 2 || DIVISOR > 255) begin : g_bad_divisor
      $error("serial_mod_n_checker: DIVISOR must be in 2..255");
   end

   state_t        state;
   logic          start;
   logic [RW-1:0] rem_src;
   logic [RW:0]   rem_a;
   logic [RW-1:0] rem_next;
   logic [LW-1:0] len_next;
   logic          ovf_next;
   logic          at_max;

   assign start   = in_valid && (state != RUN);
   assign rem_src = start ? '0 : out_rem;
   assign at_max  = (out_len == LW'(MAX_LEN));

`ifdef SERIAL_MOD_LSB_FIRST_EN
   logic          lsb_q;
   logic          lsb_src;
   logic [RW-1:0] w;
   logic [RW-1:0] w_src;
   logic [RW-1:0] w_next;

   assign lsb_src = start ? lsb_first : lsb_q;
   assign w_src   = start ? RW'(1) : w;

   // LSB-first adds b*w; MSB-first shifts the remainder and appends b
   always_comb begin
      rem_a = {rem_src, in_bit};
      if (lsb_src) rem_a = {1'b0, rem_src} + (in_bit ? {1'b0, w_src} : '0);
   end

   mod_n_step #(.DIVISOR(DIVISOR)) u_w_step (
      .a ({w_src, 1'b0}),
      .y (w_next)
   );

   // Bit weight and mode, captured at frame start and advanced per bit
   always_ff @(posedge clk) begin
      if (reset) begin
         lsb_q <= 1'b0;
         w     <= RW'(1);
      end else if (in_valid) begin
         lsb_q <= lsb_src;
         w     <= w_next;
      end
   end
`else
   assign rem_a = {rem_src, in_bit};
`endif

   mod_n_step #(.DIVISOR(DIVISOR)) u_rem_step (
      .a (rem_a),
      .y (rem_next)
   );

   // Frame length saturates; overflow is sticky until the next frame start
   always_comb begin
      if (start) begin
         len_next = LW'(1);
         ovf_next = 1'b0;
      end else begin
         len_next = at_max ? out_len : out_len + LW'(1);
         ovf_next = err_ovf | at_max;
      end
   end

   // Frame state machine with registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         out_rem  <= '0;
         out_div  <= 1'b1;
         out_len  <= '0;
         out_done <= 1'b0;
         busy     <= 1'b0;
         err_ovf  <= 1'b0;
      end else begin
         out_done <= in_valid && in_last;
         if (in_valid) begin
            out_rem <= rem_next;
            out_div <= (rem_next == '0);
            out_len <= len_next;
            err_ovf <= ovf_next;
            state   <= in_last ? DONE : RUN;
            busy    <= !in_last;
         end else if (state == DONE) begin
            state <= IDLE;
            busy  <= 1'b0;
         end
      end
   end

endmodule

// File: doc/serial_mod_n_checker.md
Name: serial_mod_n_checker

Overview:
Parametrised successor to the fixed divide-by-three serial detector. Accepts a framed serial bitstream one bit per valid cycle and tracks the running value modulo DIVISOR. Reports a running divisible flag, the remainder, the frame length and an end-of-frame done pulse. Used as a streaming divisibility/checksum helper on serial links in the lab datapath.

Parameters:
DIVISOR, 3, modulus N; legal range 2..255 (elaboration error outside this range).
MAX_LEN, 32, maximum frame length in bits; counter saturates here.
RW (localparam), $clog2(DIVISOR), remainder width (minimum 1).
LW (localparam), $clog2(MAX_LEN+1), length counter width.

Ports:
clk  in  1  system clock; all logic on the rising edge.
reset  in  1  synchronous, active-high reset.
in_valid  in  1  in_bit is consumed this cycle.
in_bit  in  1  serial data bit, MSB-first by default.
in_last  in  1  qualifies the final bit of a frame; ignored when in_valid=0.
out_div  out  1  registered; 1 when the current remainder is 0.
out_rem  out  RW  registered running remainder.
out_len  out  LW  bits accepted in the current frame, saturating at MAX_LEN.
out_done  out  1  one-cycle pulse; the final result of a frame is valid.
busy  out  1  high while a frame is open (RUN state).
err_ovf  out  1  sticky per frame; frame exceeded MAX_LEN bits.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on port reset.
- Reset values: state=IDLE, out_rem=0, out_div=1, out_len=0, out_done=0, busy=0, err_ovf=0. Reset mid-frame discards the frame; no done pulse is issued.
- State machine: IDLE, RUN, DONE.
  - IDLE, or DONE, with in_valid=1: start a new frame. The remainder seed is 0, so r=(0*2+b) mod N, out_len=1, err_ovf=0.
    - If in_last=1 in that same cycle, go to DONE (single-bit frame). Otherwise go to RUN.
  - RUN with in_valid=1: r <= (2r+b) mod N. Because 2r+b < 2N, the reduction is a single conditional subtract of N.
    - out_len increments, saturating at MAX_LEN.
    - in_last=1 goes to DONE.
  - RUN with in_valid=0: hold all state. Gaps in the stream are legal.
  - DONE: out_done=1 for exactly the one cycle after the last bit is accepted. out_rem, out_div and out_len hold until the next accepted bit.
  - DONE with in_valid=0 goes to IDLE next cycle, outputs held. DONE with in_valid=1 is a back-to-back frame and is handled as in IDLE.
- Latency: outputs reflect an accepted bit 1 cycle after acceptance. out_div always equals (out_rem==0) in the same cycle.
- Overflow: a bit accepted while out_len==MAX_LEN sets err_ovf. The remainder stays exact, since modular arithmetic never overflows. out_len holds at MAX_LEN. err_ovf clears at the next frame start.
- in_last with in_valid=0 has no effect.

Optional Feature:
Macro SERIAL_MOD_LSB_FIRST_EN.
- Defined: adds input port lsb_first (1 bit), sampled at frame start and held for the whole frame.
  - When lsb_first=1: r <= (r + b·w) mod N, then w <= (2w) mod N. w is seeded to 1 mod N at frame start, so the first bit's term uses w=1.
  - Each step is again a single conditional subtract. The w register (RW bits) is reset to 1 mod N.
- Undefined: no lsb_first port, no w register; MSB-first only.

Decomposition:
- Package serial_mod_pkg: state enum (IDLE, RUN, DONE) and a width helper function (safe clog2 with a minimum of 1).
- Sub-module mod_n_step: combinational, parameter DIVISOR. Inputs a (RW+1 bits) with a < 2N; output a mod N.
  - Instantiated once for the remainder update.
  - Instantiated a second time for the w update when the macro is enabled.

Test Plan:
1. DIVISOR=3; frame 0,1,1,1,0,0,1,1 (value 115), MSB-first, contiguous, in_last on bit 8.
   - out_rem sequence 0,1,0,1,2,1,0,1.
   - out_div sequence 1,0,1,0,0,0,1,0.
   - out_done pulses once with out_rem=1, out_len=8.
2. DIVISOR=5; frame 1,0,1,0 (value 10) with in_valid low for 3 cycles between bits 2 and 3.
   - Outputs hold during the gap.
   - Final out_rem=0, out_div=1, out_len=4, out_done single pulse.
3. Back-to-back frames, DIVISOR=3: frame 1,1 immediately followed by frame 1,0,0.
   - First done shows rem 0, len 2.
   - Second done shows rem 1, len 3. The second frame's first bit is accepted in the first frame's DONE cycle.
4. Reset mid-frame: assert reset after 3 bits of scenario 1.
   - Next cycle shows reset values and no out_done.
   - A new frame 1,1,0 then gives rem 0, out_div=1.
5. MAX_LEN=4, DIVISOR=7; frame of 6 ones (value 63).
   - err_ovf rises on the 5th bit.
   - Final out_len=4, out_rem=0, err_ovf=1.
   - err_ovf clears at the next frame's first bit.
6. With SERIAL_MOD_LSB_FIRST_EN, DIVISOR=3, lsb_first=1; bits 1,1,0,0,1,1,1,0 (115 LSB-first).
   - Final out_rem=1.
   - Same frame with lsb_first=0 gives out_rem=2 (value 206).
